exp_mailbox: RTL and testbench
==============================

# exp_mailbox

Full-duplex word mailbox that answers on the I/O expansion bus. It is the responder end of the bus: it consumes the per-register load and read strobes and load data from the bus expander, and it drives the register words back. The MCU pops an inbound FIFO through a read-sensitive data register and pushes an outbound FIFO through a write-sensitive data register. The hardware ends of both FIFOs are valid/ready streams, which makes the block a register-mapped word channel between target firmware and fabric logic.

## Interface
- DEPTH, 8, entries per FIFO; power of two, 2..16
- WIDTH, 16, word width; equals bus width
- sysclk  in  1  system clock; all state on posedge
- sysreset_n  in  1  asynchronous, active-low reset
- r_load_data  in  WIDTH  expansion-bus write data
- data_load  in  1  write strobe, mailbox data register (push outbound)
- data_read  in  1  read strobe, mailbox data register (pop inbound)
- status_load  in  1  write strobe, status register (W1C)
- data_out  out  WIDTH  inbound head word; 0 when inbound is empty
- status_out  out  16  status word
- in_data  in  WIDTH  hardware producer word
- in_valid  in  1  producer has a word
- in_ready  out  1  inbound not full
- out_data  out  WIDTH  outbound head word
- out_valid  out  1  outbound not empty
- out_ready  in  1  consumer accepts the word
- wm_load  in  1  write strobe, watermark register (MBOX_WATERMARK_EN only)
- wm_out  out  16  watermark register readback, {11'b0, wm[4:0]} (MBOX_WATERMARK_EN only)
- rx_irq  out  1  registered watermark flag (MBOX_WATERMARK_EN only)

## Operation
- Inbound path: push when in_valid && in_ready. in_ready = !rx_full; it does not depend on a same-cycle pop.
- Inbound pop: on data_read when rx is not empty. data_out shows the head combinationally during the strobe cycle, and the next head from the following cycle.
- Inbound underflow: data_read with rx empty gives data_out = 0, sets sticky rx_underflow, and leaves pointers unchanged.
- Outbound push: on data_load when tx is not full; the word is r_load_data.
- Outbound overflow: data_load with tx full drops the word and sets sticky tx_overflow. Fullness is evaluated before any same-cycle out_ready pop.
- Outbound pop: when out_valid && out_ready.
- Status bits:
  - [0] rx_nonempty
  - [1] tx_full
  - [2] tx_overflow
  - [3] rx_underflow
  - [4] rx_wm
  - [9:5] rx_count
  - [14:10] tx_count
  - [15] 0
- status_load with 1 in bit 2 or bit 3 clears that sticky bit. If a set condition and a clear occur in the same cycle, set wins. All other bits ignore writes.
- Counts run 0..DEPTH in 5 bits. Pointers are log2(DEPTH) bits and wrap naturally. Full = (count == DEPTH).
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged.
- Inbound empty with push and data_read in the same cycle: the read underflows and the pushed word is retained.

## Timing
- Reset values (asynchronous, immediate): both FIFOs empty, pointers 0, stickies 0, wm 0.
- Outputs at reset: data_out 0, status_out 0x0001-free (all zero), in_ready 1, out_valid 0, out_data 0, rx_irq 0.
- Latency: a word pushed at edge N is visible on data_out and out_valid after edge N, i.e. in cycle N+1. There is no bypass.
- status_out is combinational from registered state. Its counts reflect all pushes and pops up to the last edge.
- Strobes are single-cycle. A strobe held for k cycles acts k times; each cycle is an independent access.
- Reset asserted mid-transfer discards all contents; there are no partial words.

## Configuration
- MBOX_WATERMARK_EN defined:
  - Adds the 5-bit wm register, written from r_load_data[4:0] on wm_load and reset to 0.
  - rx_wm = (wm != 0) && (rx_count >= wm).
  - rx_irq is rx_wm registered: one cycle later, cleared at reset.
- MBOX_WATERMARK_EN undefined: wm_load, wm_out and rx_irq are absent, and status bit 4 reads 0.

## Structure
- Status bit index constants (MBOX_ST_RX_NONEMPTY … MBOX_ST_TX_COUNT_LSB) and the count width go in the shared header package. Drivers in the target program use the same names.
- Sub-module mbox_fifo is instantiated twice (inbound, outbound).
  - Parameters: DEPTH, WIDTH.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Pop when empty and push when full are ignored internally. Stickies live in exp_mailbox.

## Test plan
- Reset, then push inbound 0x1234, 0xBEEF: data_out = 0x1234 and status[9:5] = 2. data_read gives 0xBEEF next cycle; a second data_read gives empty, data_out = 0.
- data_read with inbound empty: data_out = 0, status[3] = 1. status_load with 0x0008 clears it; status_load with 0x0004 leaves bit 3 set.
- Write 9 words with DEPTH=8 and out_ready=0: in_ready stays 1 and tx_full = 1 after 8 words. The 9th sets tx_overflow. Drain gives words 1..8 in order.
- Inbound full, with in_valid and data_read in the same cycle: in_ready = 0, so there is no push. Count becomes 7 and in_ready = 1 next cycle.
- Outbound with one word, data_load and out_ready in the same cycle: the pop succeeds, the new word is stored, and tx_count stays 1.
- With MBOX_WATERMARK_EN, wm=3: rx_irq rises one cycle after the 3rd inbound push and falls one cycle after the count drops to 2. With wm=0 it never rises.

Source files
------------

// File: rtl/exp_mailbox_pkg.sv
// exp_mailbox_pkg: shared definitions for the expansion-bus word mailbox.
//   - Status register bit positions, shared with target-side driver code.
//   - Width of the FIFO occupancy counters (0..16 fits in 5 bits).
// Optional feature macro used by the mailbox: MBOX_WATERMARK_EN.
package exp_mailbox_pkg;

  localparam int MBOX_COUNT_W = 5;

  localparam int MBOX_ST_RX_NONEMPTY  = 0;
  localparam int MBOX_ST_TX_FULL      = 1;
  localparam int MBOX_ST_TX_OVERFLOW  = 2;
  localparam int MBOX_ST_RX_UNDERFLOW = 3;
  localparam int MBOX_ST_RX_WM        = 4;
  localparam int MBOX_ST_RX_COUNT_LSB = 5;
  localparam int MBOX_ST_TX_COUNT_LSB = 10;

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: synchronous word FIFO used for both mailbox directions.
// Ports:
//   sysclk, sysreset_n : clock, asynchronous active-low reset
//   push, wdata        : write a word (ignored when full)
//   pop                : discard the head word (ignored when empty)
//   rdata              : head word, forced to 0 when empty
//   count              : occupancy 0..DEPTH
//   full, empty        : occupancy flags
// Fullness and emptiness are judged on the registered count, so a push and a
// pop in the same cycle are each gated only by the state before the edge.
module mbox_fifo
  import exp_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                    sysclk,
  input  logic                    sysreset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [MBOX_COUNT_W-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [MBOX_COUNT_W-1:0] FULL_COUNT = MBOX_COUNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is never reset; the empty gate keeps stale words off rdata.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/exp_mailbox.sv
// exp_mailbox: full-duplex word mailbox on the I/O expansion bus.
// The MCU pops the inbound FIFO by reading the data register (data_read) and
// pushes the outbound FIFO by writing it (data_load). Fabric logic fills the
// inbound FIFO and drains the outbound FIFO over valid/ready streams.
//
// Handshake: a word moves on a stream exactly in a cycle where valid && ready
// are both high at the rising edge; in_ready depends only on registered state
// (not full), and out_valid only on registered state (not empty).
//
// Ports:
//   sysclk, sysreset_n          : clock, asynchronous active-low reset
//   r_load_data                 : bus write data
//   data_load / data_read       : data register write / read strobes
//   status_load                 : status register write strobe (W1C bits 2,3)
//   data_out, status_out        : register readback
//   in_data/in_valid/in_ready   : inbound producer stream
//   out_data/out_valid/out_ready: outbound consumer stream
//   wm_load, wm_out, rx_irq     : watermark register and flag
//                                 (present only with MBOX_WATERMARK_EN)
module exp_mailbox
  import exp_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic [WIDTH-1:0] r_load_data,
  input  logic             data_load,
  input  logic             data_read,
  input  logic             status_load,
  output logic [WIDTH-1:0] data_out,
  output logic [15:0]      status_out,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef MBOX_WATERMARK_EN
  input  logic             wm_load,
  output logic [15:0]      wm_out,
  output logic             rx_irq,
`endif
  input  logic             out_ready
);

  logic [MBOX_COUNT_W-1:0] rx_count;
  logic [MBOX_COUNT_W-1:0] tx_count;
  logic                    rx_full;
  logic                    rx_empty;
  logic                    tx_full;
  logic                    tx_empty;
  logic                    rx_push;
  logic                    tx_pop;
  logic                    tx_overflow;
  logic                    rx_underflow;
  logic                    rx_wm;

  assign in_ready  = !rx_full;
  assign rx_push   = in_valid && in_ready;
  assign out_valid = !tx_empty;
  assign tx_pop    = out_valid && out_ready;

  mbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .push       (rx_push),
    .pop        (data_read),
    .wdata      (in_data),
    .rdata      (data_out),
    .count      (rx_count),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  // data_load while full is dropped inside the FIFO; fullness is the
  // pre-edge value, so a same-cycle consumer pop does not make room.
  mbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .push       (data_load),
    .pop        (tx_pop),
    .wdata      (r_load_data),
    .rdata      (out_data),
    .count      (tx_count),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  // Sticky error bits: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (data_load && tx_full)
        tx_overflow <= 1'b1;
      else if (status_load && r_load_data[MBOX_ST_TX_OVERFLOW])
        tx_overflow <= 1'b0;

      if (data_read && rx_empty)
        rx_underflow <= 1'b1;
      else if (status_load && r_load_data[MBOX_ST_RX_UNDERFLOW])
        rx_underflow <= 1'b0;
    end
  end

`ifdef MBOX_WATERMARK_EN
  logic [4:0] wm;

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wm     <= '0;
      rx_irq <= 1'b0;
    end else begin
      if (wm_load) wm <= r_load_data[4:0];
      rx_irq <= rx_wm;
    end
  end

  // wm == 0 disables the flag rather than making it permanently true.
  assign rx_wm  = (wm != '0) && (rx_count >= wm);
  assign wm_out = {11'b0, wm};
`else
  assign rx_wm = 1'b0;
`endif

  always_comb begin
    status_out = '0;
    status_out[MBOX_ST_RX_NONEMPTY]  = !rx_empty;
    status_out[MBOX_ST_TX_FULL]      = tx_full;
    status_out[MBOX_ST_TX_OVERFLOW]  = tx_overflow;
    status_out[MBOX_ST_RX_UNDERFLOW] = rx_underflow;
    status_out[MBOX_ST_RX_WM]        = rx_wm;
    status_out[MBOX_ST_RX_COUNT_LSB +: MBOX_COUNT_W] = rx_count;
    status_out[MBOX_ST_TX_COUNT_LSB +: MBOX_COUNT_W] = tx_count;
  end

endmodule

// File: tb/tb_exp_mailbox.sv
module tb_exp_mailbox;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             sysclk = 1'b0;
  logic             sysreset_n = 1'b0;
  logic [WIDTH-1:0] r_load_data = '0;
  logic             data_load = 1'b0;
  logic             data_read = 1'b0;
  logic             status_load = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic [15:0]      status_out;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef MBOX_WATERMARK_EN
  logic             wm_load = 1'b0;
  logic [15:0]      wm_out;
  logic             rx_irq;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  exp_mailbox #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .sysclk      (sysclk),
    .sysreset_n  (sysreset_n),
    .r_load_data (r_load_data),
    .data_load   (data_load),
    .data_read   (data_read),
    .status_load (status_load),
    .data_out    (data_out),
    .status_out  (status_out),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
`ifdef MBOX_WATERMARK_EN
    .wm_load     (wm_load),
    .wm_out      (wm_out),
    .rx_irq      (rx_irq),
`endif
    .out_ready   (out_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle();
    data_load   = 1'b0;
    data_read   = 1'b0;
    status_load = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    r_load_data = '0;
    in_data     = '0;
`ifdef MBOX_WATERMARK_EN
    wm_load     = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    sysreset_n = 1'b0;
    tick();
    tick();
    sysreset_n = 1'b1;
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; in_data = 16'h7777;
    data_load = 1'b1; r_load_data = 16'h3333;
    tick();
    idle();
    #2;
    sysreset_n = 1'b0;          // asynchronous, between edges
    #1;
    tests_run++;
    if (data_out !== 16'h0 || status_out !== 16'h0 || in_ready !== 1'b1 ||
        out_valid !== 1'b0 || out_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: data_out=%h status=%h in_ready=%b out_valid=%b out_data=%h, want 0 0 1 0 0",
               data_out, status_out, in_ready, out_valid, out_data);
    end
`ifdef MBOX_WATERMARK_EN
    tests_run++;
    if (rx_irq !== 1'b0 || wm_out !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_wm: rx_irq=%b wm_out=%h, want 0 0", rx_irq, wm_out);
    end
`endif
    tick();
    sysreset_n = 1'b1;
    tick();
  endtask

  task automatic test_inbound();
    do_reset();
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (data_out !== 16'h1234 || status_out[9:5] !== 5'd2) begin
      tests_failed++;
      $display("FAIL inbound_head: data_out=%h rx_count=%0d, want 1234 2", data_out, status_out[9:5]);
    end
    data_read = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 16'h1234) begin
      tests_failed++;
      $display("FAIL inbound_strobe_head: data_out=%h, want 1234", data_out);
    end
    tick();
    data_read = 1'b0;
    #1;
    tests_run++;
    if (data_out !== 16'hBEEF || status_out[9:5] !== 5'd1) begin
      tests_failed++;
      $display("FAIL inbound_second: data_out=%h rx_count=%0d, want beef 1", data_out, status_out[9:5]);
    end
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    #1;
    tests_run++;
    if (data_out !== 16'h0 || status_out[0] !== 1'b0 || status_out[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL inbound_empty: data_out=%h status=%h, want 0 with bits0,3 clear", data_out, status_out);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    data_read = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 16'h0) begin
      tests_failed++;
      $display("FAIL underflow_data: data_out=%h, want 0", data_out);
    end
    tick();
    data_read = 1'b0;
    #1;
    tests_run++;
    if (status_out !== 16'h0008) begin
      tests_failed++;
      $display("FAIL underflow_set: status=%h, want 0008", status_out);
    end
    status_load = 1'b1; r_load_data = 16'h0004;
    tick();
    status_load = 1'b0;
    #1;
    tests_run++;
    if (status_out[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_wrong_clear: bit3=%b, want 1", status_out[3]);
    end
    status_load = 1'b1; r_load_data = 16'h0008;
    tick();
    status_load = 1'b0;
    #1;
    tests_run++;
    if (status_out[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_clear: bit3=%b, want 0", status_out[3]);
    end
    // set and clear in the same cycle: set wins
    data_read = 1'b1; status_load = 1'b1; r_load_data = 16'h0008;
    tick();
    idle();
    #1;
    tests_run++;
    if (status_out[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_set_wins: bit3=%b, want 1", status_out[3]);
    end
    // push and underflowing read in the same cycle: word is kept
    status_load = 1'b1; r_load_data = 16'h0008;
    tick();
    status_load = 1'b0;
    data_read = 1'b1; in_valid = 1'b1; in_data = 16'hCAFE;
    tick();
    idle();
    #1;
    tests_run++;
    if (data_out !== 16'hCAFE || status_out[9:5] !== 5'd1 || status_out[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_with_push: data_out=%h status=%h, want cafe count1 bit3", data_out, status_out);
    end
  endtask

  task automatic test_outbound_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      data_load = 1'b1; r_load_data = WIDTH'(i);
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || status_out[1] !== (i == 9) || status_out[2] !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovf_fill_%0d: in_ready=%b tx_full=%b tx_ovf=%b, want 1 %b 0",
                 i, in_ready, status_out[1], status_out[2], (i == 9));
      end
      tick();
    end
    data_load = 1'b0;
    #1;
    tests_run++;
    if (status_out[2] !== 1'b1 || status_out[14:10] !== 5'd8) begin
      tests_failed++;
      $display("FAIL ovf_set: tx_ovf=%b tx_count=%0d, want 1 8", status_out[2], status_out[14:10]);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        tests_failed++;
        $display("FAIL drain_%0d: out_valid=%b out_data=%h, want 1 %h", i, out_valid, out_data, WIDTH'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || status_out[14:10] !== 5'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: out_valid=%b out_data=%h tx_count=%0d, want 0 0 0",
               out_valid, out_data, status_out[14:10]);
    end
  endtask

  task automatic test_inbound_full_read();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 16'hA000 + WIDTH'(i);
      tick();
    end
    data_read = 1'b1; in_data = 16'hFFFF;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || status_out[9:5] !== 5'd8) begin
      tests_failed++;
      $display("FAIL full_read_ready: in_ready=%b rx_count=%0d, want 0 8", in_ready, status_out[9:5]);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || status_out[9:5] !== 5'd7 || data_out !== 16'hA001) begin
      tests_failed++;
      $display("FAIL full_read_after: in_ready=%b rx_count=%0d data_out=%h, want 1 7 a001",
               in_ready, status_out[9:5], data_out);
    end
  endtask

  task automatic test_outbound_simul();
    do_reset();
    data_load = 1'b1; r_load_data = 16'hA5A5;
    tick();
    r_load_data = 16'h5A5A; out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'hA5A5) begin
      tests_failed++;
      $display("FAIL simul_head: out_valid=%b out_data=%h, want 1 a5a5", out_valid, out_data);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (status_out[14:10] !== 5'd1 || out_data !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL simul_after: tx_count=%0d out_data=%h, want 1 5a5a", status_out[14:10], out_data);
    end
  endtask

`ifdef MBOX_WATERMARK_EN
  task automatic test_watermark();
    logic [4:0] exp_cnt;
    do_reset();
    wm_load = 1'b1; r_load_data = 16'h0003;
    tick();
    wm_load = 1'b0;
    #1;
    tests_run++;
    if (wm_out !== 16'h0003) begin
      tests_failed++;
      $display("FAIL wm_readback: wm_out=%h, want 0003", wm_out);
    end
    // cycle-by-cycle: push 3, hold, pop 1, hold
    for (int c = 0; c < 7; c++) begin
      in_valid  = (c < 3);
      in_data   = WIDTH'(c);
      data_read = (c == 4);
      #1;
      exp_cnt = (c < 3) ? 5'(c) : (c <= 4) ? 5'd3 : 5'd2;
      tests_run++;
      // irq reflects the flag one cycle back: count>=3 from c=3, <3 from c=5
      if (rx_irq !== (c >= 4 && c <= 5) || status_out[4] !== (exp_cnt >= 3)) begin
        tests_failed++;
        $display("FAIL wm_cycle_%0d: rx_irq=%b rx_wm=%b, want %b %b",
                 c, rx_irq, status_out[4], (c >= 4 && c <= 5), (exp_cnt >= 3));
      end
      tick();
    end
    idle();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wm_load = 1'b1; r_load_data = 16'h0000;
    tick();
    wm_load = 1'b0;
    tick();
    tick();
    tests_run++;
    if (rx_irq !== 1'b0 || status_out[4] !== 1'b0 || status_out[9:5] !== 5'd3) begin
      tests_failed++;
      $display("FAIL wm_zero: rx_irq=%b rx_wm=%b rx_count=%0d, want 0 0 3",
               rx_irq, status_out[4], status_out[9:5]);
    end
  endtask
`endif

  // ---------------- randomized vs reference model ----------------
  task automatic test_random();
    logic [WIDTH-1:0] rx_exp_q[$];
    logic [WIDTH-1:0] tx_exp_q[$];
    logic             m_ovf;
    logic             m_ufl;
    logic [4:0]       m_wm;
    logic             m_irq;
    logic             m_wm_flag;
    logic [WIDTH-1:0] exp_data_out;
    logic [WIDTH-1:0] exp_out_data;
    logic [15:0]      exp_status;
    int               p_in;
    int               p_rd;
    int               errs;
    errs = 0;
    m_ovf = 0; m_ufl = 0; m_wm = 0; m_irq = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      // alternate phases that fill and drain the FIFOs
      p_in = ((cyc / 100) % 2 == 0) ? 80 : 25;
      p_rd = ((cyc / 100) % 2 == 0) ? 20 : 75;
      in_valid    = ($urandom_range(0, 99) < p_in);
      in_data     = WIDTH'($urandom);
      data_read   = ($urandom_range(0, 99) < p_rd);
      data_load   = ($urandom_range(0, 99) < p_in);
      out_ready   = ($urandom_range(0, 99) < p_rd);
      status_load = ($urandom_range(0, 99) < 8);
      r_load_data = WIDTH'($urandom);
`ifdef MBOX_WATERMARK_EN
      wm_load = ($urandom_range(0, 99) < 4);
      if (wm_load) r_load_data[4:0] = 5'($urandom_range(0, 9));
`endif
      #1;
      m_wm_flag = (m_wm != 0) && (rx_exp_q.size() >= int'(m_wm));
      exp_data_out = (rx_exp_q.size() > 0) ? rx_exp_q[0] : '0;
      exp_out_data = (tx_exp_q.size() > 0) ? tx_exp_q[0] : '0;
      exp_status = {1'b0, 5'(tx_exp_q.size()), 5'(rx_exp_q.size()), m_wm_flag,
                    m_ufl, m_ovf, (tx_exp_q.size() == DEPTH), (rx_exp_q.size() != 0)};
      tests_run++;
      if (data_out !== exp_data_out || out_data !== exp_out_data || status_out !== exp_status ||
          in_ready !== (rx_exp_q.size() < DEPTH) || out_valid !== (tx_exp_q.size() > 0)
`ifdef MBOX_WATERMARK_EN
          || rx_irq !== m_irq
`endif
         ) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d: data_out=%h out_data=%h status=%h in_ready=%b out_valid=%b, want %h %h %h %b %b",
                   cyc, data_out, out_data, status_out, in_ready, out_valid, exp_data_out, exp_out_data,
                   exp_status, (rx_exp_q.size() < DEPTH), (tx_exp_q.size() > 0));
      end
      // model update from pre-edge state
      if (data_read && rx_exp_q.size() == 0) m_ufl = 1;
      else if (status_load && r_load_data[3]) m_ufl = 0;
      if (data_load && tx_exp_q.size() == DEPTH) m_ovf = 1;
      else if (status_load && r_load_data[2]) m_ovf = 0;
      m_irq = m_wm_flag;
`ifdef MBOX_WATERMARK_EN
      if (wm_load) m_wm = r_load_data[4:0];
`endif
      begin
        logic rx_push, tx_push;
        rx_push = in_valid && (rx_exp_q.size() < DEPTH);
        tx_push = data_load && (tx_exp_q.size() < DEPTH);
        if (data_read && rx_exp_q.size() > 0) void'(rx_exp_q.pop_front());
        if (out_ready && tx_exp_q.size() > 0) void'(tx_exp_q.pop_front());
        if (rx_push) rx_exp_q.push_back(in_data);
        if (tx_push) tx_exp_q.push_back(r_load_data);
      end
      tick();
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_inbound();
    test_underflow();
    test_outbound_overflow();
    test_inbound_full_read();
    test_outbound_simul();
`ifdef MBOX_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
